dtack_generator: RTL

- Bus-cycle terminator for the 68000 bus, downstream of the boot/address-decode logic.
- Consumes AS, BOOT, the region chip selects and IACK.
- Per bus cycle, drives DTACK after a per-region wait count, or VPA for autovectored interrupt acknowledge.
- Drives BERR when no acknowledge occurs within a watchdog window.

---
 rtl/mackerel_bus_pkg.sv | 43 ++++
 rtl/sync2.sv | 27 ++
 rtl/dtack_generator.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mackerel_bus_pkg.sv
// Shared definitions for the mackerel bus-cycle logic: FSM encoding, region
// codes, default timing constants and the select-priority decode.
package mackerel_bus_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    typedef enum logic [2:0] {
        REG_NONE = 3'd0,
        REG_ROM  = 3'd1,
        REG_RAM  = 3'd2,
        REG_IO   = 3'd3,
        REG_IACK = 3'd4
    } region_e;

    localparam int DEF_ROM_WAIT = 2;
    localparam int DEF_RAM_WAIT = 0;
    localparam int DEF_IO_WAIT  = 4;
    localparam int DEF_TIMEOUT  = 64;
    localparam int DEF_CNT_W    = 8;

    // All inputs active-low except boot. Until boot ends, every non-IACK
    // access is treated as ROM so the reset vectors come out of ROM timing.
    function automatic region_e decode_region(
        input logic iack_n,
        input logic boot,
        input logic cs_rom_n,
        input logic cs_ram_n,
        input logic cs_io_n
    );
        region_e r;
        if (!iack_n)        r = REG_IACK;
        else if (!boot)     r = REG_ROM;
        else if (!cs_rom_n) r = REG_ROM;
        else if (!cs_ram_n) r = REG_RAM;
        else if (!cs_io_n)  r = REG_IO;
        else                r = REG_NONE;
        return r;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs; the reset value
// is chosen per instance.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dtack_generator.sv
// 68000 bus-cycle terminator: acknowledges each AS cycle with DTACK (or VPA
// for interrupt acknowledge) after a per-region wait, or BERR on timeout.
//
// state | meaning
// IDLE  | no cycle in progress, all strobes released
// WAIT  | cycle detected, counting toward the region wait or the timeout
// ACK   | DTACK (VPA for IACK) asserted until AS is released
// ERR   | BERR asserted until AS is released
module dtack_generator
    import mackerel_bus_pkg::*;
#(
    parameter int ROM_WAIT = DEF_ROM_WAIT,
    parameter int RAM_WAIT = DEF_RAM_WAIT,
    parameter int IO_WAIT  = DEF_IO_WAIT,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic CLK,
    input  logic RST,
    input  logic AS,
    input  logic BOOT,
    input  logic IACK,
    input  logic CS_ROM,
    input  logic CS_RAM,
    input  logic CS_IO,
    output logic DTACK,
    output logic VPA,
    output logic BERR
);

    if (TIMEOUT <= ROM_WAIT || TIMEOUT <= RAM_WAIT || TIMEOUT <= IO_WAIT) begin : g_bad_timeout
        $error("dtack_generator: TIMEOUT must exceed every wait count");
    end
    if (TIMEOUT >= (2 ** CNT_W)) begin : g_bad_cnt_w
        $error("dtack_generator: CNT_W too narrow to hold TIMEOUT");
    end

    localparam logic [CNT_W-1:0] ROM_W_C   = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] RAM_W_C   = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] IO_W_C    = CNT_W'(IO_WAIT);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    function automatic logic [CNT_W-1:0] wait_for(input region_e r);
        logic [CNT_W-1:0] w;
        case (r)
            REG_ROM: w = ROM_W_C;
            REG_RAM: w = RAM_W_C;
            REG_IO:  w = IO_W_C;
            default: w = '0;
        endcase
        return w;
    endfunction

    logic             as_s;
    logic             as_prev_q;
    logic             start;
    region_e          region_now;
    logic [CNT_W-1:0] wait_now;

    logic [1:0]       state_q,  state_d;
    region_e          region_q, region_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             dtack_q,  dtack_d;
    logic             vpa_q,    vpa_d;
    logic             berr_q,   berr_d;

    // Reset value 0 means an AS held low through reset never looks like a
    // new cycle; AS has to be seen high first.
    sync2 #(.RST_VAL(1'b0)) u_as_sync (
        .clk_i  (CLK),
        .rst_ni (RST),
        .d_i    (AS),
        .q_o    (as_s)
    );

    assign start      = !as_s && as_prev_q;
    assign region_now = decode_region(IACK, BOOT, CS_ROM, CS_RAM, CS_IO);
    assign wait_now   = wait_for(region_now);

    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    region_d = region_now;
                    if (region_now != REG_NONE && wait_now == '0) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_WAIT: begin
                // Abort wins over both acknowledge and timeout on the same edge.
                if (as_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (region_q != REG_NONE && cnt_q == wait_for(region_q)) begin
                    state_d = ST_ACK;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d = ST_ERR;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_ACK, ST_ERR: begin
                if (as_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        dtack_d = !(state_d == ST_ACK && region_d != REG_IACK);
        vpa_d   = !(state_d == ST_ACK && region_d == REG_IACK);
        berr_d  = !(state_d == ST_ERR);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            as_prev_q <= 1'b0;
            state_q   <= ST_IDLE;
            region_q  <= REG_NONE;
            cnt_q     <= '0;
            dtack_q   <= 1'b1;
            vpa_q     <= 1'b1;
            berr_q    <= 1'b1;
        end else begin
            as_prev_q <= as_s;
            state_q   <= state_d;
            region_q  <= region_d;
            cnt_q     <= cnt_d;
            dtack_q   <= dtack_d;
            vpa_q     <= vpa_d;
            berr_q    <= berr_d;
        end
    end

    assign DTACK = dtack_q;
    assign VPA   = vpa_q;
    assign BERR  = berr_q;

endmodule
